// File: rtl/fifo_share_ctrl_pkg.sv
// Shared types for the fifo sharing controller.
// Read-sequencer state encodings live here so the top and the bench agree.
package fifo_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rdState_e;

endpackage

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps,
// returning a one-hot grant plus the winning index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic          found;
    logic [IW-1:0] posIdx;

    always_comb begin
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        posIdx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            posIdx = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[posIdx]) begin
                found         = 1'b1;
                grant[posIdx] = 1'b1;
                idx           = posIdx;
            end
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one status-less fifo between N_REQ producers and one consumer,
// tracking occupancy here and never issuing a write and a read together.
module fifo_share_ctrl
    import fifo_share_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        cons_req,
    output logic                        cons_valid,
    output logic [DATA_WIDTH-1:0]       cons_data,
    output logic                        fifo_we,
    output logic [DATA_WIDTH-1:0]       fifo_wdata,
    output logic                        fifo_re,
    input  logic [DATA_WIDTH-1:0]       fifo_rdata,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        full,
    output logic                        empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = ADDR_WIDTH + 1;

    rdState_e       state;
    rdState_e       stateNext;
    logic [IW-1:0]  rrPtr;
    logic [IW-1:0]  gntIdx;
    logic [IW-1:0]  ptrNext;
    logic [N_REQ-1:0] gnt;
    logic           lastRd;
    logic           wrOk;
    logic           rdOk;
    logic           doWr;
    logic           doRd;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) uArb (
        .req   (req_valid),
        .ptr   (rrPtr),
        .grant (gnt),
        .idx   (gntIdx)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Gating with reset keeps every strobe quiet while reset is held.
    always_comb begin
        wrOk = reset && (|req_valid) && !full;
        rdOk = reset && cons_req && !empty && (state == IDLE);
        doRd = rdOk && (!wrOk || !lastRd);
        doWr = wrOk && !doRd;
    end

    assign fifo_we    = doWr;
    assign fifo_re    = doRd;
    assign req_ready  = doWr ? gnt : '0;
    assign fifo_wdata = req_data[gntIdx*DATA_WIDTH +: DATA_WIDTH];
    assign cons_valid = (state == RD_DONE);
    assign ptrNext    = (gntIdx == IW'(N_REQ - 1)) ? '0 : gntIdx + 1'b1;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (doRd) stateNext = RD_WAIT;
            RD_WAIT: stateNext = RD_DONE;
            RD_DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            rrPtr     <= '0;
            lastRd    <= 1'b0;
            cons_data <= '0;
        end else begin
            state <= stateNext;
            if (doWr) begin
                count  <= count + 1'b1;
                rrPtr  <= ptrNext;
                lastRd <= 1'b0;
            end else if (doRd) begin
                count  <= count - 1'b1;
                lastRd <= 1'b1;
            end
            if (state == RD_WAIT) cons_data <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl: fifo stand-in, directed table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_share_ctrl;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            cons_req = 1'b0;
    logic            cons_valid;
    logic [DW-1:0]   cons_data;
    logic            fifo_we;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_re;
    logic [DW-1:0]   fifo_rdata;
    logic [AW:0]     count;
    logic            full;
    logic            empty;

    fifo_share_ctrl #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cons_req   (cons_req),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .fifo_re    (fifo_re),
        .fifo_rdata (fifo_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared fifo: registered read port, shares the reset.
    logic [DW-1:0] fq[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            fifo_rdata <= '0;
        end else begin
            if (fifo_we) fq.push_back(fifo_wdata);
            if (fifo_re && fq.size() > 0) fifo_rdata <= fq.pop_front();
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, pointer, fairness bit, outstanding read age.
    int            mCount, mPtr, mLeft;
    bit            mLastRd;
    logic [DW-1:0] mQ[$];
    logic [DW-1:0] mPend;
    logic [N-1:0]  mGrant;

    task automatic modelReset();
        mCount  = 0;
        mPtr    = 0;
        mLeft   = 0;
        mLastRd = 0;
        mPend   = '0;
        mGrant  = '0;
        mQ.delete();
    endtask

    task automatic modelCheck();
        bit           wrOk, rdOk, doRd, doWr, found;
        int           g, p;
        logic [N-1:0] expReady;
        wrOk = (req_valid != 0) && (mCount < DEPTH);
        rdOk = cons_req && (mCount > 0) && (mLeft == 0);
        doRd = rdOk && (!wrOk || !mLastRd);
        doWr = wrOk && !doRd;
        g = 0;
        found = 0;
        for (int k = 0; k < N; k++) begin
            p = (mPtr + k) % N;
            if (!found && req_valid[p]) begin
                found = 1;
                g = p;
            end
        end
        expReady = doWr ? (N'(1) << g) : '0;
        chk("fifo_we", fifo_we, doWr);
        chk("fifo_re", fifo_re, doRd);
        chk("req_ready", req_ready, expReady);
        if (doWr) chk("fifo_wdata", fifo_wdata, req_data[g*DW +: DW]);
        chk("count", count, mCount);
        chk("full", full, mCount == DEPTH);
        chk("empty", empty, mCount == 0);
        chk("cons_valid", cons_valid, mLeft == 1);
        if (mLeft == 1) chk("cons_data", cons_data, mPend);
        mGrant = expReady;
        if (mLeft > 0) mLeft--;
        if (doWr) begin
            mQ.push_back(req_data[g*DW +: DW]);
            mCount++;
            mPtr = (g + 1) % N;
            mLastRd = 0;
        end
        if (doRd) begin
            mPend = mQ.pop_front();
            mCount--;
            mLeft = 2;
            mLastRd = 1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        modelCheck();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] rv, input logic cr);
        req_valid = rv;
        cons_req  = cr;
    endtask

    task automatic setData(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    // Async reset applied mid-cycle with producers and consumer still asking.
    task automatic doReset(input string tag);
        req_valid = '1;
        cons_req  = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_cvalid"}, cons_valid, 0);
        chk({tag, "_cdata"}, cons_data, 0);
        chk({tag, "_we_re"}, {fifo_we, fifo_re}, 0);
        modelReset();
        drive('0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]  rv;
        logic          cr;
        logic [N-1:0]  ready;
        logic          we;
        logic          re;
        logic [AW:0]   cnt;
        logic          full;
        logic          cv;
        logic [DW-1:0] cd;
    } vec_t;

    vec_t tbl[16];
    int   pw, pr;

    initial begin
        modelReset();
        for (int i = 0; i < 8; i++)
            tbl[i] = '{4'hF, 1'b0, N'(1) << (i % 4), 1'b1, 1'b0, 4'(i), 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 32'hD000_0000};
        tbl[13] = '{4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{4'hF, 1'b0, 4'h2, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 32'hD000_0001};

        @(posedge clk);
        #1;
        reset = 1'b1;
        adv();

        // Producer 1 write then a consumer read of the same word.
        setData(1, 32'hA5A5_0001);
        drive(4'b0010, 1'b0);
        settle();
        chk("t2_ready", req_ready, 4'b0010);
        chk("t2_we", fifo_we, 1);
        adv();
        drive(4'b0000, 1'b1);
        settle();
        chk("t2_re", fifo_re, 1);
        adv();
        drive(4'b0000, 1'b0);
        settle();
        chk("t2_wait_cv", cons_valid, 0);
        adv();
        settle();
        chk("t2_cv", cons_valid, 1);
        chk("t2_cd", cons_data, 32'hA5A5_0001);
        adv();

        // Empty: consumer waits, read issues right after the write lands.
        drive(4'b0000, 1'b1);
        settle();
        chk("t5_no_re", fifo_re, 0);
        adv();
        setData(0, 32'h0000_1234);
        drive(4'b0001, 1'b1);
        settle();
        chk("t5_we", fifo_we, 1);
        chk("t5_re_blocked", fifo_re, 0);
        adv();
        drive(4'b0000, 1'b1);
        settle();
        chk("t5_re", fifo_re, 1);
        adv();
        drive(4'b0000, 1'b0);
        settle();
        adv();
        settle();
        chk("t5_cd", cons_data, 32'h0000_1234);
        chk("t5_cv", cons_valid, 1);
        adv();

        // Table: fill from rr_ptr=0 to full, then interleave reads.
        doReset("t1");
        for (int i = 0; i < N; i++) setData(i, 32'hD000_0000 | i);
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].rv, tbl[v].cr);
            settle();
            chk($sformatf("tbl%0d_ready", v), req_ready, tbl[v].ready);
            chk($sformatf("tbl%0d_we", v), fifo_we, tbl[v].we);
            chk($sformatf("tbl%0d_re", v), fifo_re, tbl[v].re);
            chk($sformatf("tbl%0d_cnt", v), count, tbl[v].cnt);
            chk($sformatf("tbl%0d_full", v), full, tbl[v].full);
            chk($sformatf("tbl%0d_cv", v), cons_valid, tbl[v].cv);
            if (tbl[v].cv) chk($sformatf("tbl%0d_cd", v), cons_data, tbl[v].cd);
            adv();
        end

        // count=3 with one producer and the consumer both held.
        doReset("t4r");
        for (int i = 0; i < 3; i++) begin
            setData(2, 32'hC0DE_0000 + i);
            drive(4'b0100, 1'b0);
            settle();
            adv();
        end
        for (int c = 0; c < 15; c++) begin
            setData(2, 32'hBEEF_0000 + c);
            drive(4'b0100, 1'b1);
            settle();
            chk("t4_excl", fifo_we & fifo_re, 0);
            adv();
        end
        drive('0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            adv();
        end

        // Reset while a read sits in RD_WAIT drops it.
        setData(3, 32'h7777_0001);
        drive(4'b1000, 1'b0);
        settle();
        adv();
        drive(4'b0000, 1'b1);
        settle();
        chk("t6_re", fifo_re, 1);
        adv();
        doReset("t6");
        drive(4'b0000, 1'b1);
        settle();
        chk("t6_no_cv", cons_valid, 0);
        chk("t6_no_re", fifo_re, 0);
        adv();
        settle();
        chk("t6_no_cv2", cons_valid, 0);
        adv();
        setData(1, 32'h7777_0002);
        drive(4'b0010, 1'b1);
        settle();
        adv();
        drive(4'b0000, 1'b1);
        settle();
        chk("t6_re_after_wr", fifo_re, 1);
        adv();

        // Randomized traffic in fill-heavy, drain-heavy and balanced phases.
        for (int c = 0; c < 900; c++) begin
            pw = (c < 300) ? 80 : ((c < 600) ? 15 : 50);
            pr = (c < 300) ? 20 : ((c < 600) ? 90 : 60);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || mGrant[i] || $urandom_range(0, 15) == 0) begin
                    req_valid[i] = ($urandom_range(0, 99) < pw);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            cons_req = ($urandom_range(0, 99) < pr);
            settle();
            chk("rnd_excl", fifo_we & fifo_re, 0);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
